des_decrypt: RTL and testbench
==============================

DES_DECRYPT -- requirements
Module: des_decrypt

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by FIPS 46-3.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request strobe; sampled on a rising clk edge.
REQ-005 desIn  input  [1:64]  ciphertext block; bit 1 is the MSB, FIPS numbering.
REQ-006 keyIn  input  [1:64]  64-bit key including parity bits, which are ignored.
REQ-007 desOut  output  [1:64]  recovered plaintext, registered.
REQ-008 ready  output  1  one-cycle pulse; desOut is valid from this cycle onward.
REQ-009 busy  output  1  high while rounds are in progress.

Function
REQ-010 The block SHALL implement FIPS 46-3 DES decryption, so that desOut equals DES-decrypt(keyIn, desIn).
REQ-011 The FSM SHALL have exactly three states:
- IDLE: waiting for a request.
- ROUND: processing rounds.
- DONE: result available, one cycle only.
REQ-012 Start acceptance:
- start=1 is accepted only in IDLE or DONE.
- On the accepting edge: desIn and keyIn are captured, IP(desIn) loads the L/R registers, PC-1(keyIn) loads the C/D registers.
- Then round counter = 1 and state goes to ROUND.
REQ-013 start while busy=1 SHALL be ignored; the in-flight operation and captured operands are unaffected.
REQ-014 Round timing:
- One Feistel round per clock in ROUND.
- Round i (i=1..16) uses subkey K(17-i), i.e. K16 first.
- Update: L <= R; R <= L xor f(R, subkey).
REQ-015 Subkey generation SHALL be iterative on the C/D registers; no 16-entry key table:
- Round 1 uses PC-2(C0,D0) directly.
- Before rounds 2..16, C and D are each rotated RIGHT by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 respectively.
REQ-016 f SHALL be E-expansion, XOR with the 48-bit subkey, the eight standard S-boxes, then P permutation; all combinational within the round cycle.
REQ-017 Completion, on the edge that executes round 16:
- desOut <= FP({R16, L16}), i.e. halves swapped before the final permutation.
- State goes to DONE.
REQ-018 ready SHALL be 1 only in DONE; this is the cycle beginning 16 rising edges after the accepting edge. Latency start-to-ready = 16 clocks.
REQ-019 DONE SHALL go to IDLE on the next edge unless start=1, in which case a new operation is accepted (back-to-back, throughput one block per 17 clocks).
REQ-020 busy SHALL equal (state == ROUND).
REQ-021 desOut SHALL hold its value from completion until the next completion or reset; it SHALL NOT change during ROUND.
REQ-022 Changes on desIn/keyIn after the accepting edge SHALL NOT affect the result.
REQ-023 Round-counter rules:
- 5 bits wide.
- Never exceeds 16.
- Returns to 0 in IDLE/DONE.

Reset
REQ-024 When rst_n=0, all of the following SHALL clear asynchronously and immediately: state=IDLE, round counter=0, L/R/C/D=0, desOut=64'h0, ready=0, busy=0.
REQ-025 Reset asserted mid-operation SHALL abort it; no ready pulse SHALL follow.
REQ-026 After rst_n deasserts, a start on the first rising edge SHALL be accepted normally.

Verification
REQ-027 Known-answer test: keyIn=133457799BBCDFF1, desIn=85E813540F0AB405, start for 1 cycle -> ready exactly 16 clocks later, desOut=0123456789ABCDEF, busy high for 16 cycles.
REQ-028 All-zero test: keyIn=0000000000000000, desIn=8CA64DE9C1B123A7 -> desOut=0000000000000000.
REQ-029 Key parity test: repeat REQ-027 with keyIn=123456789ABCDEF0 versus keyIn=133557799BBCDFF1-style parity-flipped variants (LSB of each byte toggled) -> identical desOut.
REQ-030 Busy-start test: pulse start again at round 5 with different operands -> ignored; REQ-027 result and timing unchanged; single ready pulse.
REQ-031 Back-to-back test: start held high in the DONE cycle with the REQ-028 vector -> second ready 16 clocks later with desOut=0000000000000000; first result visible in the intervening cycles.
REQ-032 Mid-run reset: assert rst_n=0 at round 8 -> desOut=0, ready=0, busy=0 immediately; no ready thereafter until a new start.

Source files
------------

// File: rtl/des_decrypt.sv
// rtl/des_decrypt.sv - iterative DES decryption core, one Feistel round per clock
module des_decrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] desIn,
    input  logic [1:64] keyIn,
    output logic [1:64] desOut,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits (8, 16, ... 64) never appear here, so they cannot affect the result
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Row-major S-box contents: entry = row*16 + column
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
          4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
          4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
          4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
        '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
          4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
          4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
          4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
        '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
          4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
          4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
        '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
          4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
          4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
          4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
        '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
          4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
          4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
          4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
        '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
          4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
          4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
          4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
        '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
          4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
          4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
          4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
        '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
          4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
          4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
          4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
    };

    function automatic logic [1:64] perm_ip(input logic [1:64] x);
        logic [1:64] o;
        for (int i = 0; i < 64; i++) o[i+1] = x[IP_T[i]];
        return o;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] x);
        logic [1:64] o;
        for (int i = 0; i < 64; i++) o[i+1] = x[FP_T[i]];
        return o;
    endfunction

    function automatic logic [1:56] perm_pc1(input logic [1:64] x);
        logic [1:56] o;
        for (int i = 0; i < 56; i++) o[i+1] = x[PC1_T[i]];
        return o;
    endfunction

    function automatic logic [1:48] perm_pc2(input logic [1:56] x);
        logic [1:48] o;
        for (int i = 0; i < 48; i++) o[i+1] = x[PC2_T[i]];
        return o;
    endfunction

    function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] o;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[i+1] = r[E_T[i]] ^ k[i+1];
        for (int n = 0; n < 8; n++) begin
            b = x[6*n+1 +: 6];
            // Outer bits pick the row, inner four bits pick the column
            s[4*n+1 +: 4] = SBOX[n][{b[5], b[0], b[4:1]}];
        end
        for (int i = 0; i < 32; i++) o[i+1] = s[P_T[i]];
        return o;
    endfunction

    state_t      r_state;
    logic [4:0]  r_round;
    logic [1:32] r_l;
    logic [1:32] r_r;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic [1:64] r_out;
    logic        r_ready;
    logic        r_busy;

    logic [1:64] w_ip;
    logic [1:56] w_pc1;
    logic [1:48] w_subkey;
    logic [1:32] w_new_r;
    logic        w_rot_one;
    logic [1:28] w_c_next;
    logic [1:28] w_d_next;
    logic [1:64] w_fp;

    assign w_ip     = perm_ip(desIn);
    assign w_pc1    = perm_pc1(keyIn);
    assign w_subkey = perm_pc2({r_c, r_d});
    assign w_new_r  = r_l ^ feistel(r_r, w_subkey);

    // Decryption walks the key schedule backwards: rotate right, single step after rounds 1, 8, 15
    assign w_rot_one = (r_round == 5'd1) || (r_round == 5'd8) || (r_round == 5'd15);
    assign w_c_next  = w_rot_one ? {r_c[28], r_c[1:27]} : {r_c[27:28], r_c[1:26]};
    assign w_d_next  = w_rot_one ? {r_d[28], r_d[1:27]} : {r_d[27:28], r_d[1:26]};

    assign w_fp = perm_fp({w_new_r, r_r});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_round <= 5'd0;
            r_l     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_ready <= 1'b0;
                    if (start) begin
                        r_l     <= w_ip[1:32];
                        r_r     <= w_ip[33:64];
                        r_c     <= w_pc1[1:28];
                        r_d     <= w_pc1[29:56];
                        r_round <= 5'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_ROUND;
                    end else begin
                        r_round <= 5'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ROUND: begin
                    r_l <= r_r;
                    r_r <= w_new_r;
                    r_c <= w_c_next;
                    r_d <= w_d_next;
                    if (r_round == 5'd16) begin
                        r_out   <= w_fp;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_round <= 5'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_round <= r_round + 5'd1;
                    end
                end
                default: begin
                    r_round <= 5'd0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign desOut = r_out;
    assign ready  = r_ready;
    assign busy   = r_busy;

endmodule

// File: tb/tb_des_decrypt.sv
// tb/tb_des_decrypt.sv - scoreboard bench for des_decrypt with known-answer vectors
module tb_des_decrypt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:64] desIn = '0;
    logic [1:64] keyIn = '0;
    logic [1:64] desOut;
    logic        ready;
    logic        busy;

    des_decrypt dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .desIn  (desIn),
        .keyIn  (keyIn),
        .desOut (desOut),
        .ready  (ready),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:64] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_run = 0;
    logic [1:64] last_out = '0;

    logic [63:0] v_din [5];
    logic [63:0] v_key [5];
    logic [63:0] v_exp [5];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every ready pulse against the scoreboard and the output hold in between
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready cycle=%0d desOut=%h", cyc, desOut);
                end else begin
                    m_e = sb_q.pop_front();
                    checks++;
                    if (desOut !== m_e.data) begin
                        errors++;
                        $display("FAIL result got=%h exp=%h", desOut, m_e.data);
                    end
                    checks++;
                    if (cyc != m_e.cyc) begin
                        errors++;
                        $display("FAIL ready_cycle got=%0d exp=%0d", cyc, m_e.cyc);
                    end
                    checks++;
                    if (busy_run != 16) begin
                        errors++;
                        $display("FAIL busy_cycles got=%0d exp=16", busy_run);
                    end
                    last_out = m_e.data;
                end
                busy_run = 0;
            end else if (busy) begin
                checks++;
                if (desOut !== last_out) begin
                    errors++;
                    $display("FAIL hold_during_round got=%h exp=%h", desOut, last_out);
                end
            end
        end
    end

    task automatic issue(input logic [63:0] din, input logic [63:0] key, input logic [63:0] exp);
        exp_t e;
        desIn = din;
        keyIn = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.data = exp;
        e.cyc  = cyc + 16;
        sb_q.push_back(e);
        start = 1'b0;
        desIn = {$urandom, $urandom};
        keyIn = {$urandom, $urandom};
    endtask

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout waited=40 cycles");
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        v_din[0] = 64'h85E813540F0AB405; v_key[0] = 64'h133457799BBCDFF1; v_exp[0] = 64'h0123456789ABCDEF;
        v_din[1] = 64'h8CA64DE9C1B123A7; v_key[1] = 64'h0000000000000000; v_exp[1] = 64'h0000000000000000;
        v_din[2] = 64'h85E813540F0AB405; v_key[2] = 64'h123556789ABDDEF0; v_exp[2] = 64'h0123456789ABCDEF;
        v_din[3] = 64'h85E813540F0AB405; v_key[3] = 64'h123456799ABCDEF1; v_exp[3] = 64'h0123456789ABCDEF;
        v_din[4] = 64'h8CA64DE9C1B123A7; v_key[4] = 64'h0101010101010101; v_exp[4] = 64'h0000000000000000;

        #2 rst_n = 1'b0;
        #1;
        check("reset_desOut", desOut, 64'h0);
        check("reset_ready", {63'h0, ready}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(v_din[i], v_key[i], v_exp[i]);
            wait_ready();
            @(negedge clk);
        end

        // start pulsed while round 5 is executing must be ignored
        issue(v_din[0], v_key[0], v_exp[0]);
        repeat (4) @(posedge clk);
        #1;
        desIn = v_din[1];
        keyIn = v_key[3];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready();
        repeat (20) @(negedge clk);

        // back-to-back: start held in the DONE cycle
        issue(v_din[0], v_key[0], v_exp[0]);
        wait_ready();
        issue(v_din[1], v_key[1], v_exp[1]);
        wait_ready();
        @(negedge clk);

        // pre-load a nonzero result, then abort the next operation at round 8
        issue(v_din[0], v_key[0], v_exp[0]);
        wait_ready();
        @(negedge clk);
        issue(v_din[1], v_key[1], v_exp[1]);
        repeat (7) @(posedge clk);
        #1;
        check("midrun_busy_before", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("midrun_desOut", desOut, 64'h0);
        check("midrun_ready", {63'h0, ready}, 64'h0);
        check("midrun_busy", {63'h0, busy}, 64'h0);
        sb_q.delete();
        last_out = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("post_reset_idle_busy", {63'h0, busy}, 64'h0);
        check("post_reset_idle_desOut", desOut, 64'h0);

        issue(v_din[0], v_key[0], v_exp[0]);
        wait_ready();
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
